// File: rtl/cpu_interlock.sv
// Issue interlock for the moxie execute stage: register scoreboard, RAW/WAW hazard
// detection and MUL/DIV sequencing. Define MOXIE_INTERLOCK_FORWARD_EN for writeback bypass.
module cpu_interlock #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    output logic        stall_o,
    input  logic [3:0]  riA_i,
    input  logic [3:0]  riB_i,
    input  logic        useA_i,
    input  logic        useB_i,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_idx_i,
    input  logic [1:0]  mc_class_i,
    input  logic        wb_en_i,
    input  logic [3:0]  wb_idx_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        mc_done_o,
    output logic [15:0] pending_o,
    output logic        fwd_a_o,
    output logic        fwd_b_o
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        mc_idx_q, mc_idx_d;
    logic [15:0]       pend_q, pend_d;

    logic raw_a, raw_b, waw, byp_a, byp_b, hazard, accept, is_mc, clear_mc;

    assign raw_a = useA_i & pend_q[riA_i];
    assign raw_b = useB_i & pend_q[riB_i];
    assign waw   = wr_en_i & pend_q[wr_idx_i];

`ifdef MOXIE_INTERLOCK_FORWARD_EN
    // Only source reads may take the writeback value; destination conflicts always wait.
    assign byp_a = raw_a & wb_en_i & (wb_idx_i == riA_i);
    assign byp_b = raw_b & wb_en_i & (wb_idx_i == riB_i);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign hazard        = (raw_a & ~byp_a) | (raw_b & ~byp_b) | waw;
    assign issue_ready_o = ~hazard & (state_q == StIdle) & ~flush_i;
    assign accept        = issue_valid_i & issue_ready_o;
    assign stall_o       = ~accept;
    assign is_mc         = (mc_class_i == 2'd1) | (mc_class_i == 2'd2);
    assign fwd_a_o       = byp_a;
    assign fwd_b_o       = byp_b;
    assign pending_o     = pend_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_idx_d  = mc_idx_q;
        busy_o    = 1'b0;
        mc_done_o = 1'b0;
        clear_mc  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && is_mc) begin
                    state_d  = StRun;
                    cnt_d    = (mc_class_i == 2'd1) ? MulLoad : DivLoad;
                    mc_idx_d = wr_idx_i;
                end
            end
            StRun: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    clear_mc = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (flush_i) begin
                    cnt_d    = '0;
                    clear_mc = 1'b1;
                end else begin
                    mc_done_o = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clears first so that a same-cycle issue to the same index keeps its bit.
    always_comb begin
        pend_d = pend_q;
        if (wb_en_i) pend_d[wb_idx_i] = 1'b0;
        if (clear_mc) pend_d[mc_idx_q] = 1'b0;
        if (accept && wr_en_i) pend_d[wr_idx_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mc_idx_q <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_idx_q <= mc_idx_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_cpu_interlock.sv
// Scoreboard bench for cpu_interlock: stimulus queues expected outputs, a negedge monitor
// pops and compares them.
module tb_cpu_interlock;

`ifdef MOXIE_INTERLOCK_FORWARD_EN
    localparam logic Fwd = 1'b1;
`else
    localparam logic Fwd = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, stall;
    logic [3:0]  riA, riB, wr_idx, wb_idx;
    logic        useA, useB, wr_en, wb_en, flush;
    logic [1:0]  mc_class;
    logic        busy, mc_done, fwd_a, fwd_b;
    logic [15:0] pending;

    always #5 clk = ~clk;

    cpu_interlock #(.MUL_CYCLES(3), .DIV_CYCLES(32)) dut (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .stall_o(stall), .riA_i(riA), .riB_i(riB), .useA_i(useA), .useB_i(useB),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx), .mc_class_i(mc_class), .wb_en_i(wb_en),
        .wb_idx_i(wb_idx), .flush_i(flush), .busy_o(busy), .mc_done_o(mc_done),
        .pending_o(pending), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
    );

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Fields: ready, stall, busy, mc_done, fwd_a, fwd_b, pending[15:0]
    always @(negedge clk) begin
        exp_t        e;
        logic [21:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {issue_ready, stall, busy, mc_done, fwd_a, fwd_b, pending};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got rdy/stall/busy/done/fa/fb/pend=%b%b%b%b%b%b/%h want %b%b%b%b%b%b/%h",
                         e.name, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                         e.v[21], e.v[20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; useA = 0; useB = 0; riA = 0; riB = 0; wr_en = 0; wr_idx = 0;
        mc_class = 0; wb_en = 0; wb_idx = 0; flush = 0;
    endtask

    task automatic exp_chk(input string name, input logic rdy, input logic bsy,
                           input logic done, input logic [15:0] pend,
                           input logic fa, input logic fb);
        exp_t e;
        e.name = name;
        e.v    = {rdy, ~(issue_valid & rdy), bsy, done, fa, fb, pend};
        sb.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [3:0] wi, input logic [1:0] mc);
        idle();
        issue_valid = 1; wr_en = we; wr_idx = wi; mc_class = mc;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        exp_chk("reset", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // RAW on r3 via source A
        issue(1, 4'd3, 0);
        exp_chk("raw_issue_wr3", 1, 0, 0, 16'h0000, 0, 0);
        step();
        issue(0, 4'd0, 0); useA = 1; riA = 4'd3;
        exp_chk("raw_blocked1", 0, 0, 0, 16'h0008, 0, 0);
        step();
        exp_chk("raw_blocked2", 0, 0, 0, 16'h0008, 0, 0);
        step();
        wb_en = 1; wb_idx = 4'd3;
        exp_chk("raw_wb_cycle", Fwd, 0, 0, 16'h0008, Fwd, 0);
        step();
        wb_en = 0;
        exp_chk("raw_after_wb", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // RAW on r8 via source B, writeback in the first blocked cycle
        issue(1, 4'd8, 0);
        exp_chk("rawb_issue_wr8", 1, 0, 0, 16'h0000, 0, 0);
        step();
        issue(0, 4'd0, 0); useB = 1; riB = 4'd8; useA = 1; riA = 4'd1;
        wb_en = 1; wb_idx = 4'd8;
        exp_chk("rawb_wb_cycle", Fwd, 0, 0, 16'h0100, 0, Fwd);
        step();
        wb_en = 0;
        exp_chk("rawb_after_wb", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // Same-cycle set and clear of r5: set wins
        issue(1, 4'd5, 0); wb_en = 1; wb_idx = 4'd5;
        exp_chk("setclr_issue", 1, 0, 0, 16'h0000, 0, 0);
        step();
        idle();
        exp_chk("setclr_kept", 1, 0, 0, 16'h0020, 0, 0);
        step();
        wb_en = 1; wb_idx = 4'd5;
        exp_chk("setclr_wb", 1, 0, 0, 16'h0020, 0, 0);
        step();
        wb_idx = 4'd9;
        exp_chk("wb_nonpending", 1, 0, 0, 16'h0000, 0, 0);
        step();
        idle();
        exp_chk("wb_nonpending_after", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // WAW on r2, never bypassed
        issue(1, 4'd2, 0);
        exp_chk("waw_first", 1, 0, 0, 16'h0000, 0, 0);
        step();
        exp_chk("waw_blocked", 0, 0, 0, 16'h0004, 0, 0);
        step();
        wb_en = 1; wb_idx = 4'd2;
        exp_chk("waw_wb_cycle", 0, 0, 0, 16'h0004, 0, 0);
        step();
        wb_en = 0;
        exp_chk("waw_after_wb", 1, 0, 0, 16'h0000, 0, 0);
        step();
        idle(); wb_en = 1; wb_idx = 4'd2;
        exp_chk("waw_reissued", 1, 0, 0, 16'h0004, 0, 0);
        step();

        // MUL to r1: busy 3 cycles, done on the 4th
        issue(1, 4'd1, 1);
        exp_chk("mul_issue", 1, 0, 0, 16'h0000, 0, 0);
        step();
        issue(0, 4'd0, 0);
        for (int k = 1; k <= 3; k++) begin
            exp_chk($sformatf("mul_run%0d", k), 0, 1, 0, 16'h0002, 0, 0);
            step();
        end
        exp_chk("mul_done", 0, 0, 1, 16'h0002, 0, 0);
        step();
        wb_en = 1; wb_idx = 4'd1;
        exp_chk("mul_idle", 1, 0, 0, 16'h0002, 0, 0);
        step();

        // DIV to r4: busy 32 cycles, done on the 33rd
        issue(1, 4'd4, 2);
        exp_chk("div_issue", 1, 0, 0, 16'h0000, 0, 0);
        step();
        issue(0, 4'd0, 0);
        for (int k = 1; k <= 32; k++) begin
            exp_chk($sformatf("div_run%0d", k), 0, 1, 0, 16'h0010, 0, 0);
            step();
        end
        exp_chk("div_done", 0, 0, 1, 16'h0010, 0, 0);
        step();
        exp_chk("div_idle", 1, 0, 0, 16'h0010, 0, 0);
        step();
        wb_en = 1; wb_idx = 4'd4;
        exp_chk("div_wb", 1, 0, 0, 16'h0010, 0, 0);
        step();
        idle();
        exp_chk("div_cleared", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // Flush DIV to r7 at RUN cycle 10
        issue(1, 4'd7, 2);
        exp_chk("flush_issue", 1, 0, 0, 16'h0000, 0, 0);
        step();
        idle();
        for (int k = 1; k <= 9; k++) begin
            exp_chk($sformatf("flush_run%0d", k), 0, 1, 0, 16'h0080, 0, 0);
            step();
        end
        flush = 1;
        exp_chk("flush_run10", 0, 1, 0, 16'h0080, 0, 0);
        step();
        flush = 0;
        exp_chk("flush_after", 1, 0, 0, 16'h0000, 0, 0);
        step();
        exp_chk("flush_no_done", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // Flush in IDLE blocks issue only
        issue(1, 4'd6, 0); flush = 1;
        exp_chk("flush_idle", 0, 0, 0, 16'h0000, 0, 0);
        step();
        idle();
        exp_chk("flush_idle_after", 1, 0, 0, 16'h0000, 0, 0);
        step();

        // Reset in the middle of a MUL to r6
        issue(1, 4'd6, 1);
        exp_chk("rst_mid_issue", 1, 0, 0, 16'h0000, 0, 0);
        step();
        idle(); rst = 1;
        exp_chk("rst_mid_run", 0, 1, 0, 16'h0040, 0, 0);
        step();
        rst = 0;
        exp_chk("rst_mid_after", 1, 0, 0, 16'h0000, 0, 0);
        step();
        exp_chk("rst_mid_no_done", 1, 0, 0, 16'h0000, 0, 0);
        step();

        step();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
